imem_fetch_sync: RTL and testbench

//  Parametrised, clocked instruction memory for the IF stage. Replaces the combinational ROM.

---
 rtl/imem_fetch_sync.sv | 106 ++++++++++
 tb/tb_imem_fetch_sync.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sync.sv
module imem_fetch_sync #(
  parameter int             N         = 32,
  parameter int             D         = 32,
  parameter int             BYTE_ADDR = 0,
  parameter logic [N-1:0]   NOP_INST  = 32'hFC000000,
  parameter string          INIT_FILE = ""
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 fetch_en,
  input  logic [N-1:0]                         fetch_addr,
  input  logic                                 stall,
  input  logic                                 flush,
  input  logic                                 prog_we,
  input  logic [((D > 1) ? $clog2(D) : 1)-1:0] prog_addr,
  input  logic [N-1:0]                         prog_data,
  output logic [N-1:0]                         instruction,
  output logic                                 inst_valid,
  output logic                                 addr_fault,
  output logic                                 is_mem,
  output logic                                 is_branch,
  output logic                                 is_jump
);

  localparam int           AW       = (D > 1) ? $clog2(D) : 1;
  localparam logic [N-1:0] DEPTH_N  = N'(D);
  localparam logic [AW:0]  PA_LIMIT = (AW + 1)'(D);

  logic [N-1:0] mem [D] = '{default: NOP_INST};

  logic [N-1:0]  idx;
  logic [AW-1:0] ridx;
  logic          misalign;
  logic          out_range;
  logic [N-1:0]  rd_word;

  logic [N-1:0]  nxt_inst;
  logic          nxt_valid;
  logic          nxt_fault;
  logic [2:0]    nxt_pd;
  logic          hold;

  function automatic logic [2:0] predecode(input logic [5:0] op);
    logic [2:0] r;
    r = '0;
    unique case (op)
      6'b000000, 6'b000001: r = 3'b100;
      6'b000010:            r = 3'b010;
      6'b000011:            r = 3'b001;
      default:              r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    idx       = (BYTE_ADDR != 0) ? (fetch_addr >> 2) : fetch_addr;
    misalign  = (BYTE_ADDR != 0) && (fetch_addr[1:0] != 2'b00);
    out_range = (idx >= DEPTH_N);
    ridx      = idx[AW-1:0];
    rd_word   = mem[ridx];
  end

  // flush beats stall; an unflushed stall freezes every output register
  always_comb begin
    nxt_inst  = NOP_INST;
    nxt_valid = 1'b0;
    nxt_fault = 1'b0;
    nxt_pd    = '0;
    hold      = stall && !flush;
    if (!flush && fetch_en) begin
      nxt_valid = 1'b1;
      if (misalign || out_range) begin
        nxt_fault = 1'b1;
      end else begin
        nxt_inst = rd_word;
        nxt_pd   = predecode(rd_word[N-1 -: 6]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= NOP_INST;
      inst_valid  <= 1'b0;
      addr_fault  <= 1'b0;
      is_mem      <= 1'b0;
      is_branch   <= 1'b0;
      is_jump     <= 1'b0;
    end else if (!hold) begin
      instruction <= nxt_inst;
      inst_valid  <= nxt_valid;
      addr_fault  <= nxt_fault;
      is_mem      <= nxt_pd[2];
      is_branch   <= nxt_pd[1];
      is_jump     <= nxt_pd[0];
    end
  end

  // read above sees the pre-edge contents, so same-cycle write/fetch is read-first
  always_ff @(posedge clk) begin
    if (!reset && prog_we && ({1'b0, prog_addr} < PA_LIMIT)) begin
      mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_sync.sv
// Directed bench for imem_fetch_sync: word- and byte-addressed instances checked
// every cycle against an abstract memory/fetch model, plus literal spot checks.
module tb_imem_fetch_sync;

    localparam logic [31:0] NOP = 32'hFC000000;
    localparam logic [31:0] W0  = 32'h0041_0004; // lw
    localparam logic [31:0] W1  = 32'h1043_0020; // add-like, opcode 000100
    localparam logic [31:0] W2  = 32'h0441_0008; // sw
    localparam logic [31:0] W3  = 32'h0822_0003; // beq
    localparam logic [31:0] W4  = 32'h0C00_0010; // jump
    localparam logic [31:0] W5N = 32'h1111_1111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;

    logic [31:0] inst0, inst1;
    logic        v0, v1, f0, f1, m0, m1, b0, b1, j0, j1;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    imem_fetch_sync #(.N(32), .D(32), .BYTE_ADDR(0)) dut_w (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .instruction(inst0), .inst_valid(v0),
        .addr_fault(f0), .is_mem(m0), .is_branch(b0), .is_jump(j0));

    imem_fetch_sync #(.N(32), .D(32), .BYTE_ADDR(1)) dut_b (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .stall(stall), .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .instruction(inst1), .inst_valid(v1),
        .addr_fault(f1), .is_mem(m1), .is_branch(b1), .is_jump(j1));

    typedef struct packed {
        logic [31:0] inst;
        logic        v;
        logic        f;
        logic [2:0]  pd;
    } out_t;

    logic [31:0] model_mem [32];
    out_t e0, e1;

    function automatic logic [2:0] classify(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'd0 || op == 6'd1) return 3'b100;
        if (op == 6'd2) return 3'b010;
        if (op == 6'd3) return 3'b001;
        return 3'b000;
    endfunction

    function automatic out_t bubble();
        out_t r;
        r.inst = NOP; r.v = 1'b0; r.f = 1'b0; r.pd = 3'b000;
        return r;
    endfunction

    function automatic out_t fetch_model(input logic [31:0] a, input bit byte_mode);
        out_t r;
        longint unsigned w;
        w = byte_mode ? longint'(a) / 4 : longint'(a);
        r.v = 1'b1;
        if ((byte_mode && (a % 4) != 0) || w >= 32) begin
            r.inst = NOP; r.f = 1'b1; r.pd = 3'b000;
        end else begin
            r.inst = model_mem[w]; r.f = 1'b0; r.pd = classify(r.inst);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            e0 = bubble(); e1 = bubble();
            chk_on = 1'b1;
        end else if (flush) begin
            e0 = bubble(); e1 = bubble();
        end else if (stall) begin
            e0 = e0; e1 = e1;
        end else if (fetch_en) begin
            e0 = fetch_model(fetch_addr, 1'b0);
            e1 = fetch_model(fetch_addr, 1'b1);
        end else begin
            e0 = bubble(); e1 = bubble();
        end
        if (!reset && prog_we) model_mem[prog_addr] = prog_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("w.inst",  inst0, e0.inst);
            check("w.valid", {31'b0, v0}, {31'b0, e0.v});
            check("w.fault", {31'b0, f0}, {31'b0, e0.f});
            check("w.pd",    {29'b0, m0, b0, j0}, {29'b0, e0.pd});
            check("b.inst",  inst1, e1.inst);
            check("b.valid", {31'b0, v1}, {31'b0, e1.v});
            check("b.fault", {31'b0, f1}, {31'b0, e1.f});
            check("b.pd",    {29'b0, m1, b1, j1}, {29'b0, e1.pd});
        end
    end

    task automatic step(input logic rst, input logic fe, input logic [31:0] fa,
                        input logic st, input logic fl,
                        input logic we, input logic [4:0] pa, input logic [31:0] pdat);
        reset = rst; fetch_en = fe; fetch_addr = fa; stall = st; flush = fl;
        prog_we = we; prog_addr = pa; prog_data = pdat;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] prog [5];

    initial begin
        for (int i = 0; i < 32; i++) model_mem[i] = NOP;
        prog[0] = W0; prog[1] = W1; prog[2] = W2; prog[3] = W3; prog[4] = W4;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("lit.reset.inst",  inst0, NOP);
        check("lit.reset.valid", {31'b0, v0}, 32'd0);

        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 5'(i), prog[i]);
        step(0, 0, 0, 0, 0, 1, 5'd31, W4);

        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'(i), 0, 0, 0, 0, 0);
            check("lit.seq.inst", inst0, prog[i]);
            check("lit.seq.valid", {31'b0, v0}, 32'd1);
        end
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("lit.lw.pd", {29'b0, m0, b0, j0}, 32'b100);
        step(0, 1, 3, 0, 0, 0, 0, 0);
        check("lit.beq.pd", {29'b0, m0, b0, j0}, 32'b010);

        step(0, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 1, 0, 0, 0, 0);
        step(0, 1, 3, 1, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0);
        check("lit.stall.inst", inst0, W1);
        check("lit.stall.valid", {31'b0, v0}, 32'd1);

        step(0, 1, 2, 1, 1, 0, 0, 0);
        check("lit.flush.inst", inst0, NOP);
        check("lit.flush.valid", {31'b0, v0}, 32'd0);
        check("lit.flush.pd", {29'b0, m0, b0, j0}, 32'd0);

        step(0, 1, 32, 0, 0, 0, 0, 0);
        check("lit.oor.inst", inst0, NOP);
        check("lit.oor.fault", {30'b0, v0, f0}, 32'b11);
        step(0, 1, 31, 0, 0, 0, 0, 0);
        check("lit.last.inst", inst0, W4);
        step(0, 1, 6, 0, 0, 0, 0, 0);
        check("lit.mis.fault", {30'b0, v1, f1}, 32'b11);
        step(0, 1, 8, 0, 0, 0, 0, 0);
        check("lit.byte8.inst", inst1, W2);
        check("lit.byte8.fault", {31'b0, f1}, 32'd0);
        step(0, 1, 128, 0, 0, 0, 0, 0);
        check("lit.byte128.fault", {31'b0, f1}, 32'd1);
        step(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);

        step(0, 1, 5, 0, 0, 1, 5, W5N);
        check("lit.rdfirst.old", inst0, NOP);
        step(0, 1, 5, 0, 0, 0, 0, 0);
        check("lit.rdfirst.new", inst0, W5N);

        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("lit.idle.valid", {31'b0, v0}, 32'd0);

        step(0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 1, 2, 1, 0, 1, 0, 32'hDEAD_BEEF);
        check("lit.rst.inst", inst0, NOP);
        check("lit.rst.valid", {31'b0, v0}, 32'd0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("lit.rst.memkept", inst0, W0);
        step(0, 1, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
